// File: rtl/arith_pkg.sv
// arith_pkg -- shared definitions for the arithmetic blocks.
//
// Contents:
//   DEFAULT_WIDTH  default operand/result width for the divider
//   div_state_t    sequencing states of sequential_divider
package arith_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for start
        PREP = 2'd1,  // magnitudes/signs formed, first step taken
        RUN  = 2'd2,  // one restoring step per cycle
        FIN  = 2'd3   // results written, new start may be taken
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step -- one restoring division iteration (purely combinational).
//
// Ports:
//   rem_in   [WIDTH-1:0]  partial remainder before this step (< dvs)
//   dvs      [WIDTH-1:0]  divisor magnitude
//   bit_in                next dividend bit shifted into the remainder
//   rem_out  [WIDTH-1:0]  partial remainder after this step (< dvs)
//   q_bit                 quotient bit produced by this step
module div_step
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dvs,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // The shifted remainder can reach 2*dvs-1, so it needs one extra bit.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, dvs};
        q_bit   = (shifted >= {1'b0, dvs});
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/sequential_divider.sv
// sequential_divider -- multi-cycle restoring divider, one bit per cycle.
//
// Build option: define SEQ_DIV_SIGNED_EN for two's-complement signed
// division (quotient truncates toward zero, remainder takes the dividend's
// sign). Without it the operands are treated as unsigned. Latency is the same.
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   start                    request; taken in IDLE or FIN, ignored otherwise
//   dividend, divisor        operands, captured on the accepting edge (T0)
//   busy                     high from T0 until FIN
//   done                     one-cycle pulse, results valid after edge T0+WIDTH+1
//   quotient, remainder      results, held until the next result is written
//   div_by_zero              set with the results when divisor was zero
//
// Timing: T0 captures operands. At edge T0+1 PREP forms the magnitudes and
// takes the first restoring step; RUN takes the remaining WIDTH-1 steps and
// reaches FIN at edge T0+WIDTH. FIN writes the signed results and done on
// edge T0+WIDTH+1. A zero divisor goes PREP->FIN, so done follows edge T0+2.
module sequential_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [WIDTH-1:0] dvd_q;     // captured dividend
    logic [WIDTH-1:0] dvs_q;     // captured divisor
    logic [WIDTH-1:0] dvs_mag;   // divisor magnitude used by RUN
    logic [WIDTH-1:0] rem_q;     // partial remainder
    logic [WIDTH-1:0] sh_q;      // unused dividend bits above, quotient bits below
    logic             q_neg;
    logic             r_neg;
    logic             zero_q;
    logic [CW-1:0]    cnt;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] shift_src, st_rem, st_dvs, st_rem_out, sh_next;
    logic             st_q;

    // Operand magnitudes from the captured values; only meaningful in PREP.
    always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
        a_neg = dvd_q[WIDTH-1];
        b_neg = dvs_q[WIDTH-1];
`else
        a_neg = 1'b0;
        b_neg = 1'b0;
`endif
        // Negating the most-negative value yields 2**(WIDTH-1), which is the
        // correct unsigned magnitude.
        a_mag = a_neg ? -dvd_q : dvd_q;
        b_mag = b_neg ? -dvs_q : dvs_q;
    end

    // PREP feeds the step directly from the fresh magnitudes; RUN from state.
    always_comb begin
        if (state == PREP) begin
            shift_src = a_mag;
            st_rem    = '0;
            st_dvs    = b_mag;
        end else begin
            shift_src = sh_q;
            st_rem    = rem_q;
            st_dvs    = dvs_mag;
        end
        sh_next = {shift_src[WIDTH-2:0], st_q};
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (st_rem),
        .dvs     (st_dvs),
        .bit_in  (shift_src[WIDTH-1]),
        .rem_out (st_rem_out),
        .q_bit   (st_q)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dvs_mag     <= '0;
            rem_q       <= '0;
            sh_q        <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            zero_q      <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    dvs_mag <= b_mag;
                    q_neg   <= a_neg ^ b_neg;
                    r_neg   <= a_neg;
                    zero_q  <= (dvs_q == '0);
                    if (dvs_q == '0) begin
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        sh_q  <= sh_next;
                        rem_q <= st_rem_out;
                        cnt   <= CW'(1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    sh_q  <= sh_next;
                    rem_q <= st_rem_out;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIN: begin
                    done        <= 1'b1;
                    div_by_zero <= zero_q;
                    if (zero_q) begin
                        quotient  <= '1;
                        remainder <= dvd_q;
                    end else begin
                        quotient  <= q_neg ? -sh_q : sh_q;
                        remainder <= r_neg ? -rem_q : rem_q;
                    end
                    if (start) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        busy  <= 1'b1;
                        state <= PREP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
